// File: rtl/hazard_pipe_regs.sv
// -----------------------------------------------------------------------------
// hazard_pipe_regs
//
// Purpose: Decode->Execute->Mem->Writeback pipeline registers for the fields a
// hazard unit needs (source/destination registers, RegWrite, MemtoReg) plus a
// per-stage valid bit. Execute can be flushed to a bubble. Optional performance
// counters track flushed cycles and retired instructions.
//
// Configuration macro: HAZARD_PERF_COUNT_EN
//   defined   : FlushCount / RetireCount are live saturating 32-bit counters
//   undefined : FlushCount / RetireCount are tied to 0, no counter flops
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   RsD, RtD, WriteRegD          Decode register fields (5 bits each)
//   RegWriteD, MemtoRegD, ValidD Decode controls
//   FlushE                       replace the Execute load with a bubble
//   RsE, RtE, WriteRegE          Execute register fields
//   RegWriteE, MemtoRegE         Execute controls
//   WriteRegM, RegWriteM, MemtoRegM  Mem stage
//   WriteRegW, RegWriteW, ValidW     Writeback stage
//   FlushCount, RetireCount      performance counters (32 bits)
// -----------------------------------------------------------------------------
module hazard_pipe_regs (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  RsD,
   input  logic [4:0]  RtD,
   input  logic [4:0]  WriteRegD,
   input  logic        RegWriteD,
   input  logic        MemtoRegD,
   input  logic        ValidD,
   input  logic        FlushE,
   output logic [4:0]  RsE,
   output logic [4:0]  RtE,
   output logic [4:0]  WriteRegE,
   output logic        RegWriteE,
   output logic        MemtoRegE,
   output logic [4:0]  WriteRegM,
   output logic        RegWriteM,
   output logic        MemtoRegM,
   output logic [4:0]  WriteRegW,
   output logic        RegWriteW,
   output logic        ValidW,
   output logic [31:0] FlushCount,
   output logic [31:0] RetireCount
);

   // Decode controls qualified before entering Execute: a non-valid slot never
   // writes or loads, and a write to $0 is dropped here so it never propagates.
   logic w_regwrite_d;
   logic w_memtoreg_d;

   assign w_regwrite_d = RegWriteD & ValidD & (WriteRegD != 5'd0);
   assign w_memtoreg_d = MemtoRegD & ValidD;

   // Execute stage
   logic [4:0] r_rs_e;
   logic [4:0] r_rt_e;
   logic [4:0] r_wr_e;
   logic       r_regwrite_e;
   logic       r_memtoreg_e;
   logic       r_valid_e;

   // Mem stage
   logic [4:0] r_wr_m;
   logic       r_regwrite_m;
   logic       r_memtoreg_m;
   logic       r_valid_m;

   // Writeback stage
   logic [4:0] r_wr_w;
   logic       r_regwrite_w;
   logic       r_valid_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rs_e       <= 5'd0;
         r_rt_e       <= 5'd0;
         r_wr_e       <= 5'd0;
         r_regwrite_e <= 1'b0;
         r_memtoreg_e <= 1'b0;
         r_valid_e    <= 1'b0;
         r_wr_m       <= 5'd0;
         r_regwrite_m <= 1'b0;
         r_memtoreg_m <= 1'b0;
         r_valid_m    <= 1'b0;
         r_wr_w       <= 5'd0;
         r_regwrite_w <= 1'b0;
         r_valid_w    <= 1'b0;
      end else begin
         if (FlushE) begin
            // Bubble: the Decode instruction is discarded even if valid.
            r_rs_e       <= 5'd0;
            r_rt_e       <= 5'd0;
            r_wr_e       <= 5'd0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_valid_e    <= 1'b0;
         end else begin
            r_rs_e       <= RsD;
            r_rt_e       <= RtD;
            r_wr_e       <= WriteRegD;
            r_regwrite_e <= w_regwrite_d;
            r_memtoreg_e <= w_memtoreg_d;
            r_valid_e    <= ValidD;
         end
         r_wr_m       <= r_wr_e;
         r_regwrite_m <= r_regwrite_e;
         r_memtoreg_m <= r_memtoreg_e;
         r_valid_m    <= r_valid_e;
         r_wr_w       <= r_wr_m;
         r_regwrite_w <= r_regwrite_m;
         r_valid_w    <= r_valid_m;
      end
   end

`ifdef HAZARD_PERF_COUNT_EN
   logic [31:0] r_flush_cnt;
   logic [31:0] r_retire_cnt;

   // Both counters hold at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush_cnt  <= 32'd0;
         r_retire_cnt <= 32'd0;
      end else begin
         if (FlushE && (r_flush_cnt != 32'hFFFF_FFFF)) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
         if (r_valid_w && (r_retire_cnt != 32'hFFFF_FFFF)) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
         end
      end
   end

   assign FlushCount  = r_flush_cnt;
   assign RetireCount = r_retire_cnt;
`else
   assign FlushCount  = 32'd0;
   assign RetireCount = 32'd0;
`endif

   assign RsE       = r_rs_e;
   assign RtE       = r_rt_e;
   assign WriteRegE = r_wr_e;
   assign RegWriteE = r_regwrite_e;
   assign MemtoRegE = r_memtoreg_e;
   assign WriteRegM = r_wr_m;
   assign RegWriteM = r_regwrite_m;
   assign MemtoRegM = r_memtoreg_m;
   assign WriteRegW = r_wr_w;
   assign RegWriteW = r_regwrite_w;
   assign ValidW    = r_valid_w;

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// -----------------------------------------------------------------------------
// tb_hazard_pipe_regs
//
// Directed bench for hazard_pipe_regs. Each step drives one set of Decode
// inputs, pushes the expected Execute record into a three-deep scoreboard
// queue, and after the clock edge compares E/M/W outputs against the queue
// entries (newest = E, oldest = W). Counter expectations follow the
// HAZARD_PERF_COUNT_EN macro.
// -----------------------------------------------------------------------------
module tb_hazard_pipe_regs;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wr;
      logic       rw;
      logic       mtr;
      logic       v;
   } stage_t;

`ifdef HAZARD_PERF_COUNT_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [4:0]  RsD;
   logic [4:0]  RtD;
   logic [4:0]  WriteRegD;
   logic        RegWriteD;
   logic        MemtoRegD;
   logic        ValidD;
   logic        FlushE;
   logic [4:0]  RsE;
   logic [4:0]  RtE;
   logic [4:0]  WriteRegE;
   logic        RegWriteE;
   logic        MemtoRegE;
   logic [4:0]  WriteRegM;
   logic        RegWriteM;
   logic        MemtoRegM;
   logic [4:0]  WriteRegW;
   logic        RegWriteW;
   logic        ValidW;
   logic [31:0] FlushCount;
   logic [31:0] RetireCount;

   int unsigned total;
   int unsigned bad;

   stage_t      q[$];
   logic [31:0] exp_flush;
   logic [31:0] exp_retire;

   hazard_pipe_regs dut (
      .clk         (clk),
      .rst         (rst),
      .RsD         (RsD),
      .RtD         (RtD),
      .WriteRegD   (WriteRegD),
      .RegWriteD   (RegWriteD),
      .MemtoRegD   (MemtoRegD),
      .ValidD      (ValidD),
      .FlushE      (FlushE),
      .RsE         (RsE),
      .RtE         (RtE),
      .WriteRegE   (WriteRegE),
      .RegWriteE   (RegWriteE),
      .MemtoRegE   (MemtoRegE),
      .WriteRegM   (WriteRegM),
      .RegWriteM   (RegWriteM),
      .MemtoRegM   (MemtoRegM),
      .WriteRegW   (WriteRegW),
      .RegWriteW   (RegWriteW),
      .ValidW      (ValidW),
      .FlushCount  (FlushCount),
      .RetireCount (RetireCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the scoreboard after the edge.
   task automatic check_all(input string name);
      stage_t e;
      stage_t m;
      stage_t w;
      e = q[2];
      m = q[1];
      w = q[0];
      check({name, ".RsE"},         {27'd0, RsE},       {27'd0, e.rs});
      check({name, ".RtE"},         {27'd0, RtE},       {27'd0, e.rt});
      check({name, ".WriteRegE"},   {27'd0, WriteRegE}, {27'd0, e.wr});
      check({name, ".RegWriteE"},   {31'd0, RegWriteE}, {31'd0, e.rw});
      check({name, ".MemtoRegE"},   {31'd0, MemtoRegE}, {31'd0, e.mtr});
      check({name, ".WriteRegM"},   {27'd0, WriteRegM}, {27'd0, m.wr});
      check({name, ".RegWriteM"},   {31'd0, RegWriteM}, {31'd0, m.rw});
      check({name, ".MemtoRegM"},   {31'd0, MemtoRegM}, {31'd0, m.mtr});
      check({name, ".WriteRegW"},   {27'd0, WriteRegW}, {27'd0, w.wr});
      check({name, ".RegWriteW"},   {31'd0, RegWriteW}, {31'd0, w.rw});
      check({name, ".ValidW"},      {31'd0, ValidW},    {31'd0, w.v});
      check({name, ".FlushCount"},  FlushCount,  exp_flush);
      check({name, ".RetireCount"}, RetireCount, exp_retire);
   endtask

   // One clock: drive inputs, update the scoreboard, clock, compare.
   task automatic step(input string name, input logic r, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] wr, input logic rw,
                       input logic mtr, input logic vd, input logic fl);
      stage_t e;
      logic   w_valid_before;
      rst       = r;
      RsD       = rs;
      RtD       = rt;
      WriteRegD = wr;
      RegWriteD = rw;
      MemtoRegD = mtr;
      ValidD    = vd;
      FlushE    = fl;
      w_valid_before = q[0].v;
      e = '0;
      if (!r && !fl) begin
         e.rs  = rs;
         e.rt  = rt;
         e.wr  = wr;
         e.rw  = rw && vd && (wr != 5'd0);
         e.mtr = mtr && vd;
         e.v   = vd;
      end
      if (r) begin
         q.delete();
         repeat (3) q.push_back('0);
         exp_flush  = 32'd0;
         exp_retire = 32'd0;
      end else begin
         q.push_back(e);
         void'(q.pop_front());
         if (PerfEn) begin
            if (fl && exp_flush != 32'hFFFF_FFFF) exp_flush = exp_flush + 32'd1;
            if (w_valid_before && exp_retire != 32'hFFFF_FFFF) exp_retire = exp_retire + 32'd1;
         end
      end
      @(posedge clk);
      #1;
      check_all(name);
   endtask

   task automatic idle(input string name);
      step(name, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      exp_flush  = 32'd0;
      exp_retire = 32'd0;
      repeat (3) q.push_back('0);
      rst = 1'b1; RsD = '0; RtD = '0; WriteRegD = '0;
      RegWriteD = 1'b0; MemtoRegD = 1'b0; ValidD = 1'b0; FlushE = 1'b0;

      // Reset state
      step("reset0", 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      step("reset1", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Pipeline: one instruction writing r8, then bubbles until it retires
      step("pipe_d",  1'b0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
      idle("pipe_p2");
      idle("pipe_p3");
      idle("pipe_p4");
      idle("pipe_p5");

      // Writes to $0 are squashed
      step("zero_d", 1'b0, 5'd7, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle("zero_p2");
      idle("zero_p3");
      idle("zero_p4");

      // Flush discards a valid load
      step("flush_d", 1'b0, 5'd10, 5'd11, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
      idle("flush_p2");
      idle("flush_p3");
      idle("flush_p4");

      // Non-valid slot: fields pass, controls cleared
      step("inval_d", 1'b0, 5'd3, 5'd17, 5'd21, 1'b1, 1'b1, 1'b0, 1'b0);
      idle("inval_p2");

      // Back-to-back mix including a load
      step("mix0", 1'b0, 5'd31, 5'd30, 5'd29, 1'b1, 1'b1, 1'b1, 1'b0);
      step("mix1", 1'b0, 5'd12, 5'd13, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0);
      step("mix2", 1'b0, 5'd15, 5'd16, 5'd18, 1'b1, 1'b0, 1'b1, 1'b1);
      step("mix3", 1'b0, 5'd19, 5'd20, 5'd22, 1'b1, 1'b0, 1'b1, 1'b0);
      idle("mix4");
      idle("mix5");
      idle("mix6");

      // Reset mid-stream with three instructions in flight
      step("mid0", 1'b0, 5'd1, 5'd1, 5'd23, 1'b1, 1'b0, 1'b1, 1'b0);
      step("mid1", 1'b0, 5'd2, 5'd2, 5'd24, 1'b1, 1'b1, 1'b1, 1'b0);
      step("mid2", 1'b0, 5'd3, 5'd3, 5'd25, 1'b1, 1'b0, 1'b1, 1'b0);
      step("mid_rst", 1'b1, 5'd4, 5'd4, 5'd26, 1'b1, 1'b0, 1'b1, 1'b1);
      step("post_rst", 1'b0, 5'd5, 5'd6, 5'd27, 1'b1, 1'b0, 1'b1, 1'b0);
      idle("post_p2");
      idle("post_p3");
      idle("post_p4");

`ifdef HAZARD_PERF_COUNT_EN
      // Saturation: preload the flush counter just below all-ones
      force dut.r_flush_cnt = 32'hFFFF_FFFD;
      #1;
      release dut.r_flush_cnt;
      exp_flush = 32'hFFFF_FFFD;
`endif
      step("sat0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("sat1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("sat2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle("sat3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
